// File: rtl/bf_uart_rx_pkg.sv
// bf_uart_rx_pkg: shared FSM state encoding and baud divider derivation for the UART receiver
package bf_uart_rx_pkg;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;
    function automatic int baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction
endpackage

// File: rtl/bf_uart_rx_sync2.sv
// bf_uart_rx_sync2: two-flop synchronizer with a parameterised reset value
//   clk_i  in  clock
//   rst_i  in  synchronous active-high reset, loads RST_VAL into both flops
//   d_i    in  asynchronous input
//   q_o    out synchronized output, two cycles behind d_i
module bf_uart_rx_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) {q_o, meta_q} <= {RST_VAL, RST_VAL};
        else       {q_o, meta_q} <= {meta_q, d_i};
    end
endmodule

// File: rtl/bf_uart_rx.sv
// bf_uart_rx: 8N1 UART receiver with one-byte holding register, valid/ready handshake and sticky error flags
//   clk_i        in   system clock
//   rst_i        in   synchronous active-high reset
//   uart_rx_i    in   asynchronous serial line, idle high
//   rx_data_o    out  received byte, stable while rx_valid_o is high
//   rx_valid_o   out  holding register full
//   rx_ready_i   in   consumer accepts the byte when rx_valid_o is high
//   err_clr_i    in   clears both sticky flags
//   frame_err_o  out  sticky: stop bit sampled low
//   overrun_o    out  sticky: byte completed while holding register full
//   rx_busy_o    out  receiver is not idle
module bf_uart_rx
    import bf_uart_rx_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 38400
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic       err_clr_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       rx_busy_o
);
    localparam int DIV  = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(DIV - 1);

    logic          rx_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          commit_q, commit_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    bf_uart_rx_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (uart_rx_i),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            commit_q <= 1'b0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            commit_q <= commit_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        commit_d = 1'b0;
        data_d   = data_q;
        valid_d  = valid_q & ~rx_ready_i;
        ferr_d   = ferr_q & ~err_clr_i;
        ovr_d    = ovr_q & ~err_clr_i;
        // A transfer in the commit cycle frees the register for the new byte
        if (commit_q) begin
            if (!valid_q || rx_ready_i) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == CNT_END) begin
                    cnt_d    = '0;
                    commit_d = rx_s;
                    state_d  = rx_s ? IDLE : BREAK;
                    if (!rx_s) ferr_d = 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign rx_busy_o   = state_q != IDLE;
endmodule

// File: tb/tb_bf_uart_rx.sv
// tb_bf_uart_rx: randomized self-checking bench for bf_uart_rx against a byte-level line model
module tb_bf_uart_rx;
    localparam int BIT  = 16;
    localparam int DBIT = 50000000 / 38400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b1;
    logic       ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, ferr, ovr, busy;
    logic [7:0] d_data;
    logic       d_valid, d_ferr, d_ovr, d_busy;

    int checks = 0;
    int errors = 0;

    logic       col_en = 1'b0;
    logic [7:0] got[$];
    int         vcyc = 0;
    int         bfalls = 0;
    logic       prev_busy = 1'b0;

    always #5 clk = ~clk;

    bf_uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(line),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(ready),
        .err_clr_i(err_clr), .frame_err_o(ferr), .overrun_o(ovr), .rx_busy_o(busy)
    );

    bf_uart_rx dut_def (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(line),
        .rx_data_o(d_data), .rx_valid_o(d_valid), .rx_ready_i(ready),
        .err_clr_i(err_clr), .frame_err_o(d_ferr), .overrun_o(d_ovr), .rx_busy_o(d_busy)
    );

    always @(negedge clk) begin
        prev_busy <= busy;
        if (col_en) begin
            if (rx_valid) vcyc <= vcyc + 1;
            if (rx_valid && ready) got.push_back(rx_data);
            if (prev_busy && !busy) bfalls <= bfalls + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int len);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            line = bits[i];
            tick(len);
        end
    endtask

    task automatic wait_valid(input bit def, input int max, output int lat);
        lat = 0;
        while (lat < max) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if ((def ? d_valid : rx_valid) === 1'b1) break;
        end
    endtask

    task automatic pulse_at_commit(input bit clr);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (n >= 400) begin errors++; $display("FAIL commit_wait got %0d cycles exp <400", n); end
        if (clr) err_clr = 1'b1; else ready = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        ready = 1'b0;
    endtask

    task automatic drain();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        checks++;
        if ({rx_data, rx_valid, ferr, ovr, busy} !== 12'h0) begin
            errors++; $display("FAIL reset_outputs got %h exp 000", {rx_data, rx_valid, ferr, ovr, busy});
        end
        tick(1);
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_basic();
        int lat, exp_lat;
        logic [7:0] b;
        b = 8'h41;
        exp_lat = 2 + BIT / 2 + 9 * BIT + 1;
        ready = 1'b0;
        fork
            send_frame(b, 1'b1, BIT);
            wait_valid(1'b0, 400, lat);
        join
        checks++;
        if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
            errors++; $display("FAIL basic_latency got %0d exp %0d+/-1", lat, exp_lat);
        end
        @(negedge clk);
        checks++;
        if (rx_data !== b) begin errors++; $display("FAIL basic_data got %h exp %h", rx_data, b); end
        checks++;
        if ({rx_valid, ferr, ovr} !== 3'b100) begin
            errors++; $display("FAIL basic_flags got %b exp 100", {rx_valid, ferr, ovr});
        end
        tick(1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({rx_valid, rx_data} !== {1'b0, b}) begin
            errors++; $display("FAIL basic_accept got %b/%h exp 0/%h", rx_valid, rx_data, b);
        end
        tick(1);
    endtask

    task automatic test_glitch();
        line = 1'b0;
        tick(5);
        line = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b exp 1", busy); end
        tick(40);
        @(negedge clk);
        checks++;
        if ({busy, rx_valid, ferr, ovr} !== 4'b0000) begin
            errors++; $display("FAIL glitch_idle got %b exp 0000", {busy, rx_valid, ferr, ovr});
        end
        tick(1);
    endtask

    task automatic test_frame_err();
        ready = 1'b0;
        send_frame(8'hA5, 1'b0, BIT);
        tick(20 * BIT);
        @(negedge clk);
        checks++;
        if ({ferr, rx_valid, busy} !== 3'b101) begin
            errors++; $display("FAIL ferr_set got %b exp 101", {ferr, rx_valid, busy});
        end
        tick(1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(20 * BIT);
        @(negedge clk);
        checks++;
        if ({ferr, rx_valid} !== 2'b00) begin
            errors++; $display("FAIL ferr_once got %b exp 00", {ferr, rx_valid});
        end
        tick(1);
        line = 1'b1;
        tick(2 * BIT);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ferr_break_exit got %b exp 0", busy); end
        tick(1);
        send_frame(8'h3C, 1'b1, BIT);
        @(negedge clk);
        checks++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h3C}) begin
            errors++; $display("FAIL ferr_recover got %b/%h exp 1/3c", rx_valid, rx_data);
        end
        tick(1);
        drain();
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        send_frame(8'h11, 1'b1, BIT);
        fork
            send_frame(8'h22, 1'b1, BIT);
            pulse_at_commit(1'b1);
        join
        @(negedge clk);
        checks++;
        if ({rx_data, rx_valid, ovr, ferr} !== {8'h11, 3'b110}) begin
            errors++; $display("FAIL ovr_set got %h/%b exp 11/110", rx_data, {rx_valid, ovr, ferr});
        end
        tick(1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", ovr); end
        tick(1);
        drain();
        send_frame(8'h11, 1'b1, BIT);
        fork
            send_frame(8'h22, 1'b1, BIT);
            pulse_at_commit(1'b0);
        join
        @(negedge clk);
        checks++;
        if ({rx_data, rx_valid, ovr} !== {8'h22, 2'b10}) begin
            errors++; $display("FAIL ovr_same_cycle got %h/%b exp 22/10", rx_data, {rx_valid, ovr});
        end
        tick(1);
        drain();
    endtask

    task automatic test_reset_mid();
        int g0;
        ready = 1'b0;
        send_frame(8'h77, 1'b1, BIT);
        fork
            send_frame(8'hFF, 1'b1, BIT);
            begin
                tick(5 * BIT + BIT / 2);
                rst = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk);
                    @(negedge clk);
                    checks++;
                    if ({rx_data, rx_valid, ferr, ovr, busy} !== 12'h0) begin
                        errors++; $display("FAIL rst_mid_outputs got %h exp 000", {rx_data, rx_valid, ferr, ovr, busy});
                    end
                end
                tick(1);
                rst = 1'b0;
            end
        join
        g0 = got.size();
        ready = 1'b1;
        col_en = 1'b1;
        send_frame(8'h5A, 1'b1, BIT);
        tick(4);
        col_en = 1'b0;
        ready = 1'b0;
        tick(1);
        checks++;
        if (got.size() - g0 != 1) begin
            errors++; $display("FAIL rst_mid_count got %0d exp 1", got.size() - g0);
        end else begin
            checks++;
            if (got[g0] !== 8'h5A) begin errors++; $display("FAIL rst_mid_data got %h exp 5a", got[g0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        int g0, v0, f0;
        exp_q = '{8'h00, 8'hFF, 8'h55};
        g0 = got.size();
        v0 = vcyc;
        f0 = bfalls;
        ready = 1'b1;
        col_en = 1'b1;
        foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, BIT);
        tick(4);
        col_en = 1'b0;
        ready = 1'b0;
        tick(1);
        checks++;
        if (vcyc - v0 != 3) begin errors++; $display("FAIL b2b_valid_cycles got %0d exp 3", vcyc - v0); end
        checks++;
        if (bfalls - f0 != 3) begin errors++; $display("FAIL b2b_busy_falls got %0d exp 3", bfalls - f0); end
        checks++;
        if (got.size() - g0 != 3) begin
            errors++; $display("FAIL b2b_count got %0d exp 3", got.size() - g0);
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got[g0 + i] !== exp_q[i]) begin
                    errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, got[g0 + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int g0;
        g0 = got.size();
        ready = 1'b1;
        col_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1, BIT);
            tick($urandom_range(0, 20));
        end
        tick(4);
        col_en = 1'b0;
        ready = 1'b0;
        tick(1);
        checks++;
        if (got.size() - g0 != exp_q.size()) begin
            errors++; $display("FAIL rand_count got %0d exp %0d", got.size() - g0, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got[g0 + i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand_byte%0d got %h exp %h", i, got[g0 + i], exp_q[i]);
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({ferr, ovr} !== 2'b00) begin errors++; $display("FAIL rand_flags got %b exp 00", {ferr, ovr}); end
        tick(1);
    endtask

    task automatic test_defaults();
        int lat, exp_lat;
        exp_lat = 2 + DBIT / 2 + 9 * DBIT + 1;
        rst = 1'b1;
        line = 1'b1;
        tick(3);
        rst = 1'b0;
        ready = 1'b0;
        tick(2);
        fork
            send_frame(8'h96, 1'b1, DBIT);
            wait_valid(1'b1, 13500, lat);
        join
        checks++;
        if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
            errors++; $display("FAIL def_latency got %0d exp %0d+/-1", lat, exp_lat);
        end
        @(negedge clk);
        checks++;
        if ({d_data, d_valid, d_ferr, d_ovr} !== {8'h96, 3'b100}) begin
            errors++; $display("FAIL def_frame got %h/%b exp 96/100", d_data, {d_valid, d_ferr, d_ovr});
        end
        tick(1);
    endtask

    initial begin
        tick(1);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_defaults();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
